// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for a five-stage core.
// It turns hazard, branch and memory-wait conditions into freeze and flush
// strobes, sequences a debug halt through a drain phase, traps memory
// timeouts in an error state, and counts stall and flush cycles.
module pipeline_stall_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255,
    parameter int DRAIN   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             sram_ready,
    input  logic             halt_req,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic             freeze_if,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             freeze_all,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DRAIN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                memstall;
    logic                timeout;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign memstall = mem_access & ~sram_ready;
    // The stall that would complete TIMEOUT consecutive wait cycles.
    assign timeout  = memstall && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Pipeline strobes: memory wait beats branch flush beats hazard bubble.
    always_comb begin
        freeze_if    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        freeze_all   = 1'b0;
        case (state)
            ST_RUN: begin
                if (memstall) begin
                    freeze_all = 1'b1;
                end else if (branch_taken) begin
                    flush_if_id  = 1'b1;
                    flush_id_exe = 1'b1;
                end else if (hazard) begin
                    freeze_if    = 1'b1;
                    flush_id_exe = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (memstall) begin
                    freeze_all = 1'b1;
                end else begin
                    freeze_if    = 1'b1;
                    flush_id_exe = 1'b1;
                end
            end
            default: freeze_all = 1'b1;
        endcase
    end

    // Control FSM with wait/drain counters and registered halted/err flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            halted <= 1'b0;
            err    <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (timeout) begin
                        state    <= ST_ERROR;
                        wait_cnt <= '0;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= memstall ? wait_cnt + WAIT_W'(1) : '0;
                        // A taken branch flushes first; the halt is accepted a cycle later.
                        if (halt_req && !memstall && !branch_taken) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (timeout) begin
                        state    <= ST_ERROR;
                        wait_cnt <= '0;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= memstall ? wait_cnt + WAIT_W'(1) : '0;
                        if (!halt_req) begin
                            state <= ST_RUN;
                        end else if (!memstall) begin
                            if (drain_cnt == DRAIN_W'(DRAIN - 1)) begin
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt + DRAIN_W'(1);
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    wait_cnt <= '0;
                    if (!halt_req) state  <= ST_RUN;
                    else           halted <= 1'b1;
                end
                default: begin
                    wait_cnt <= '0;
                    if (err_clr) state <= ST_RUN;
                    else         err   <= 1'b1;
                end
            endcase
        end
    end

    // Performance counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze_if || freeze_all) stall_cnt <= sat_inc(stall_cnt);
            if (flush_if_id)             flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances (default and a small
// TIMEOUT=4 / CNT_W=4 variant) share one stimulus stream and are compared
// every cycle against a behavioural model, plus directed literal checks.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst, hazard, branch_taken, mem_access, sram_ready, halt_req, err_clr, cnt_clr;

    logic a_fi, a_fii, a_fie, a_fa, a_halted, a_err;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic b_fi, b_fii, b_fie, b_fa, b_halted, b_err;
    logic [3:0] b_stall_cnt, b_flush_cnt;

    int checks = 0;
    int errors = 0;

    // captured {freeze_if, flush_if_id, flush_id_exe, freeze_all, halted, err}
    logic [5:0] cap_a, cap_b;

    // model state per instance: mode 0 run, 1 draining, 2 halted, 3 error
    int m_mode[2];
    int m_stall_run[2];
    int m_bubbles[2];
    int m_sc[2];
    int m_fc[2];
    int m_to[2]  = '{255, 4};
    int m_max[2] = '{65535, 15};

    always #5 clk = ~clk;

    pipeline_stall_controller dut_a (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_access(mem_access), .sram_ready(sram_ready), .halt_req(halt_req),
        .err_clr(err_clr), .cnt_clr(cnt_clr),
        .freeze_if(a_fi), .flush_if_id(a_fii), .flush_id_exe(a_fie),
        .freeze_all(a_fa), .halted(a_halted), .err(a_err),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_stall_controller #(.CNT_W(4), .TIMEOUT(4), .DRAIN(3)) dut_b (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_access(mem_access), .sram_ready(sram_ready), .halt_req(halt_req),
        .err_clr(err_clr), .cnt_clr(cnt_clr),
        .freeze_if(b_fi), .flush_if_id(b_fii), .flush_id_exe(b_fie),
        .freeze_all(b_fa), .halted(b_halted), .err(b_err),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected strobes {fi, fii, fie, fa} from the mode and current inputs.
    function automatic logic [3:0] exp_strobes(input int md);
        logic ms;
        ms = mem_access && !sram_ready;
        if (md == 2 || md == 3) return 4'b0001;
        if (ms) return 4'b0001;
        if (md == 1) return 4'b1010;
        if (branch_taken) return 4'b0110;
        if (hazard) return 4'b1010;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_stall_run[k] = 0; m_bubbles[k] = 0;
            m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] s;
            logic ms;
            s  = exp_strobes(m_mode[k]);
            ms = mem_access && !sram_ready;
            if (cnt_clr) begin
                m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                if ((s[3] || s[0]) && m_sc[k] < m_max[k]) m_sc[k]++;
                if (s[2] && m_fc[k] < m_max[k]) m_fc[k]++;
            end
            if (m_mode[k] <= 1) begin
                m_stall_run[k] = ms ? m_stall_run[k] + 1 : 0;
                if (m_stall_run[k] == m_to[k]) begin
                    m_mode[k] = 3;
                    m_stall_run[k] = 0;
                end else if (m_mode[k] == 0) begin
                    if (!ms && halt_req && !branch_taken) begin
                        m_mode[k] = 1; m_bubbles[k] = 0;
                    end
                end else if (!halt_req) begin
                    m_mode[k] = 0;
                end else if (!ms) begin
                    m_bubbles[k]++;
                    if (m_bubbles[k] == 3) m_mode[k] = 2;
                end
            end else if (m_mode[k] == 2) begin
                m_stall_run[k] = 0;
                if (!halt_req) m_mode[k] = 0;
            end else begin
                m_stall_run[k] = 0;
                if (err_clr) m_mode[k] = 0;
            end
        end
    endtask

    task automatic compare();
        logic [3:0] ea, eb;
        ea = exp_strobes(m_mode[0]);
        eb = exp_strobes(m_mode[1]);
        cap_a = {a_fi, a_fii, a_fie, a_fa, a_halted, a_err};
        cap_b = {b_fi, b_fii, b_fie, b_fa, b_halted, b_err};
        chk("a_strobes", int'(cap_a[5:2]), int'(ea));
        chk("a_halted", int'(a_halted), int'(m_mode[0] == 2));
        chk("a_err", int'(a_err), int'(m_mode[0] == 3));
        chk("a_stall_cnt", int'(a_stall_cnt), m_sc[0]);
        chk("a_flush_cnt", int'(a_flush_cnt), m_fc[0]);
        chk("b_strobes", int'(cap_b[5:2]), int'(eb));
        chk("b_halted", int'(b_halted), int'(m_mode[1] == 2));
        chk("b_err", int'(b_err), int'(m_mode[1] == 3));
        chk("b_stall_cnt", int'(b_stall_cnt), m_sc[1]);
        chk("b_flush_cnt", int'(b_flush_cnt), m_fc[1]);
    endtask

    task automatic step(input logic h, input logic br, input logic ma, input logic rdy,
                        input logic hr, input logic ec, input logic cc, input logic r);
        @(negedge clk);
        hazard = h; branch_taken = br; mem_access = ma; sram_ready = rdy;
        halt_req = hr; err_clr = ec; cnt_clr = cc; rst = r;
        if (r) model_reset();
        #1 compare();
        @(posedge clk);
        if (!r) model_update();
    endtask

    initial begin
        int fa_cycles;
        logic seen_halt;
        logic hr_r;
        hazard = 0; branch_taken = 0; mem_access = 0; sram_ready = 1;
        halt_req = 0; err_clr = 0; cnt_clr = 0; rst = 1;
        model_reset();

        // reset state
        step(0, 0, 0, 1, 0, 0, 0, 1);
        chk("rst_strobes", int'(cap_a[5:2]), 0);
        chk("rst_halted_err", int'(cap_a[1:0]), 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        #2 chk("rst_stall_cnt", int'(a_stall_cnt), 0);

        // two hazard cycles
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 1, 0, 0, 0, 0);
            chk("haz_fi", int'(cap_a[5]), 1);
            chk("haz_fie", int'(cap_a[3]), 1);
        end
        #2 chk("haz_stall_cnt", int'(a_stall_cnt), 2);

        // branch beats hazard
        step(1, 1, 0, 1, 0, 0, 0, 0);
        chk("br_strobes", int'(cap_a[5:2]), 4'b0110);
        #2 chk("br_flush_cnt", int'(a_flush_cnt), 1);

        // five-cycle memory wait; the TIMEOUT=4 instance traps on the 4th
        fa_cycles = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1, 1, 1, 0, 0, 0, 0, 0);
            if (cap_a[2] == 1'b0 && cap_a[4] == 1'b0) fa_cycles += int'(cap_a[2]);
            fa_cycles += int'(cap_a[2]);
            #2;
            if (i == 3) chk("to_err_before", int'(b_err), 0);
            if (i == 4) chk("to_err_after", int'(b_err), 1);
        end
        chk("mem_fa_cycles", fa_cycles, 5);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        chk("mem_done_fa", int'(cap_a[2]), 0);
        chk("mem_done_err", int'(cap_a[0]), 0);
        #2 chk("mem_stall_cnt", int'(a_stall_cnt), 7);
        step(1, 1, 0, 1, 1, 0, 0, 0);
        #2 chk("err_held", int'(b_err), 1);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        #2 chk("err_cleared", int'(b_err), 0);

        // full halt: three bubbles then halted
        step(0, 0, 0, 1, 1, 0, 0, 0);
        chk("halt_enter_strobes", int'(cap_a[5:2]), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1, 0, 0, 0);
            chk("drain_bubble", int'(cap_a[5:2]), 4'b1010);
            chk("drain_not_halted", int'(cap_a[1]), 0);
        end
        #2 chk("halted_set", int'(a_halted), 1);
        step(0, 0, 0, 1, 1, 0, 0, 0);
        chk("halted_fa", int'(cap_a[2]), 1);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("halted_until_edge", int'(cap_a[1]), 1);
        #2 chk("halt_release", int'(a_halted), 0);

        // aborted halt after one drain cycle
        seen_halt = 0;
        step(0, 0, 0, 1, 1, 0, 0, 0); seen_halt |= cap_a[1];
        step(0, 0, 0, 1, 1, 0, 0, 0); seen_halt |= cap_a[1];
        step(0, 0, 0, 1, 0, 0, 0, 0); seen_halt |= cap_a[1];
        step(0, 0, 0, 1, 0, 0, 0, 0); seen_halt |= cap_a[1];
        chk("abort_strobes", int'(cap_a[5:2]), 0);
        #2 chk("abort_never_halted", int'(seen_halt | a_halted), 0);

        // saturation on the 4-bit counters, then clear with a stall
        step(0, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
        #2 chk("sat_stall_cnt", int'(b_stall_cnt), 15);
        step(1, 0, 0, 1, 0, 0, 1, 0);
        #2 chk("clr_over_stall", int'(b_stall_cnt), 0);

        // randomized traffic
        hr_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) hr_r = ~hr_r;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5,
                 hr_r, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
